// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: takes host bitstream words over valid/ready and
// serialises them MSB-first onto the configuration chain head, with a
// per-bit chain clock enable and config_enable framing.
// Optional build macro CCFF_TAIL_CRC_EN adds tail_crc, a CRC-8 (poly 0x07)
// taken over ccff_tail on every shifting cycle.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 18,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  output logic              config_enable,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done
`ifdef CCFF_TAIL_CRC_EN
  ,
  output logic [7:0]        tail_crc
`endif
);

  localparam int WORDS     = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;
  localparam int SC_W      = $clog2(WORD_W + 1);

  localparam logic [SC_W-1:0]  FULL_BITS     = SC_W'(WORD_W);
  localparam logic [SC_W-1:0]  TAIL_BITS     = SC_W'(LAST_BITS);
  localparam logic [SC_W-1:0]  ONE_BIT       = SC_W'(1);
  localparam logic [CNT_W-1:0] LAST_WORD_IDX = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CHAIN_END     = CNT_W'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [SC_W-1:0]   hold_bits_q, hold_bits_d;   // useful bits in the held word
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [SC_W-1:0]   shift_bits_q, shift_bits_d; // useful bits left to emit
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              head_q, head_d;             // last emitted bit, held when starved

  logic active;
  logic emit;
  logic refill;
  logic accept;

  // Handshake and chain-side outputs are decoded from registered state only,
  // so an asynchronous reset forces them low without waiting for a clock.
  assign active        = (state_q == LOAD) || (state_q == DRAIN);
  assign emit          = active && (shift_bits_q != '0);
  // The hold word slides in as the shifter goes empty or emits its last bit.
  assign refill        = active && hold_full_q && (shift_bits_q <= ONE_BIT);
  assign data_ready    = (state_q == LOAD) && (!hold_full_q || refill) && !abort;
  assign accept        = data_ready && data_valid;
  assign chain_clk_en  = emit;
  assign ccff_head     = emit ? shift_q[WORD_W-1] : head_q;
  assign busy          = active;
  assign config_enable = active;
  assign done          = (state_q == DONE);

  // Next-state, buffering and shifting decisions.
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    hold_bits_d  = hold_bits_q;
    shift_d      = shift_q;
    shift_bits_d = shift_bits_q;
    word_cnt_d   = word_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    head_d       = head_q;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d      = LOAD;
          hold_full_d  = 1'b0;
          shift_bits_d = '0;
          word_cnt_d   = '0;
          bit_cnt_d    = '0;
        end
      end
      LOAD, DRAIN: begin
        if (emit) begin
          head_d       = shift_q[WORD_W-1];
          shift_d      = shift_q << 1;
          shift_bits_d = shift_bits_q - ONE_BIT;
          bit_cnt_d    = bit_cnt_q + CNT_W'(1);
        end
        if (refill) begin
          shift_d      = hold_q;
          shift_bits_d = hold_bits_q;
          hold_full_d  = 1'b0;
        end
        if (accept) begin
          hold_d      = data_in;
          hold_full_d = 1'b1;
          word_cnt_d  = word_cnt_q + CNT_W'(1);
          // Only the top bits of the final word belong to the chain.
          if (word_cnt_q == LAST_WORD_IDX) begin
            hold_bits_d = TAIL_BITS;
            state_d     = DRAIN;
          end else begin
            hold_bits_d = FULL_BITS;
          end
        end
        if ((state_q == DRAIN) && (bit_cnt_d == CHAIN_END)) begin
          state_d = DONE;
        end
        if (abort) begin
          state_d      = IDLE;
          hold_full_d  = 1'b0;
          shift_bits_d = '0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      hold_bits_q  <= '0;
      shift_q      <= '0;
      shift_bits_q <= '0;
      word_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      head_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      hold_bits_q  <= hold_bits_d;
      shift_q      <= shift_d;
      shift_bits_q <= shift_bits_d;
      word_cnt_q   <= word_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      head_q       <= head_d;
    end
  end

`ifdef CCFF_TAIL_CRC_EN
  logic [7:0] crc_q, crc_d;

  assign tail_crc = crc_q;

  // CRC-8 over the bits leaving the chain; cleared when a load starts.
  always_comb begin
    crc_d = crc_q;
    if ((state_q == IDLE) && start && !abort) begin
      crc_d = 8'h00;
    end else if (emit) begin
      crc_d = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ ccff_tail) ? 8'h07 : 8'h00);
    end
  end

  // CRC register with asynchronous reset.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      crc_q <= 8'h00;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader with an 18-bit chain model on the
// head/tail pins. Build with CCFF_TAIL_CRC_EN to also cover tail_crc.
module tb_ccff_chain_loader;

  localparam logic [17:0] EXP_BITS = 18'b101001010011110011; // A5, 3C, top 2 of C0

  logic       prog_clk = 1'b0;
  logic       pReset;
  logic       start;
  logic       abort;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       ccff_head;
  logic       chain_clk_en;
  logic       config_enable;
  logic       ccff_tail;
  logic       busy;
  logic       done;
`ifdef CCFF_TAIL_CRC_EN
  logic [7:0] tail_crc;
`endif

  ccff_chain_loader #(.CHAIN_LEN(18), .WORD_W(8), .CNT_W(16)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .start         (start),
    .abort         (abort),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .ccff_head     (ccff_head),
    .chain_clk_en  (chain_clk_en),
    .config_enable (config_enable),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done)
`ifdef CCFF_TAIL_CRC_EN
    ,
    .tail_crc      (tail_crc)
`endif
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: 18 flops clocked only when the loader enables the chain.
  logic [17:0] chain_q;
  logic        chain_clr;
  always @(posedge prog_clk) begin
    if (chain_clr)         chain_q <= '0;
    else if (chain_clk_en) chain_q <= {chain_q[16:0], ccff_head};
  end
  assign ccff_tail = chain_q[17];

  // Monitor: log every enabled bit and when it happened, count done pulses,
  // and count cycles where the head moved while the chain was not shifting.
  int cyc = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int hold_viol = 0;
  bit prev_head = 1'b0;
  bit head_log [0:2047];
  int en_cyc   [0:2047];
  always @(negedge prog_clk) begin
    cyc <= cyc + 1;
    if (chain_clk_en === 1'b1) begin
      head_log[en_cnt] <= ccff_head;
      en_cyc[en_cnt]   <= cyc;
      en_cnt           <= en_cnt + 1;
    end
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (busy === 1'b1 && chain_clk_en === 1'b0 && ccff_head !== prev_head)
      hold_viol <= hold_viol + 1;
    prev_head <= ccff_head;
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy_cfg", {30'd0, busy, config_enable}, 32'd3);
  endtask

  task automatic send_word(input logic [7:0] w);
    bit got;
    got = 1'b0;
    data_in = w;
    data_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge prog_clk);
      if (data_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("word_accepted", {31'd0, got}, 32'd1);
    if (got) tick();
    data_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge prog_clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    if (got) chk("done_idle_flags", {30'd0, busy, config_enable}, 32'd0);
    tick();
  endtask

  task automatic run_load(input logic [7:0] w0, input logic [7:0] w1,
                          input logic [7:0] w2, input int gap);
    pulse_start();
    send_word(w0);
    repeat (gap) tick();
    send_word(w1);
    send_word(w2);
    wait_done();
  endtask

  // Compare the 18 bits shifted since log index b against the A5/3C/C0 load.
  task automatic check_load(input string tag, input int b, input int hv_base,
                            input int starve_exp);
    logic [17:0] obs;
    obs = '0;
    for (int i = 0; i < 18; i++) obs = {obs[16:0], head_log[b + i]};
    chk({tag, "_en_count"}, en_cnt - b, 18);
    chk({tag, "_head_bits"}, {14'd0, obs}, {14'd0, EXP_BITS});
    chk({tag, "_chain"}, {14'd0, chain_q}, {14'd0, EXP_BITS});
    chk({tag, "_starved"}, en_cyc[b + 17] - en_cyc[b] + 1 - 18, starve_exp);
    chk({tag, "_head_hold"}, hold_viol - hv_base, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    int db;
    int hv;
    bit got;

    pReset = 1'b1; start = 1'b0; abort = 1'b0;
    data_in = 8'h00; data_valid = 1'b0; chain_clr = 1'b1;
    #2;
    chk("reset_outputs", {26'd0, data_ready, ccff_head, chain_clk_en, config_enable, busy, done}, 32'd0);
    tick(); tick();
    pReset = 1'b0;
    chain_clr = 1'b0;
    tick();

    // Streaming load, data_valid back to back.
    b = en_cnt; db = done_cnt; hv = hold_viol;
    run_load(8'hA5, 8'h3C, 8'hC0, 0);
    check_load("stream", b, hv, 0);
    chk("stream_one_done", done_cnt - db, 1);

    // Host idles 5 cycles after the first word; still no gap in shifting.
    b = en_cnt; db = done_cnt; hv = hold_viol;
    run_load(8'hA5, 8'h3C, 8'hC0, 5);
    check_load("gap5", b, hv, 0);

    // Host idles 12 cycles: the first word drains and 5 cycles starve.
    b = en_cnt; hv = hold_viol;
    run_load(8'hA5, 8'h3C, 8'hC0, 12);
    check_load("gap12", b, hv, 5);
    chk("gap12_one_done", done_cnt - db, 2);

    // Abort after 7 shifted bits, then a clean full reload.
    b = en_cnt; db = done_cnt;
    pulse_start();
    send_word(8'hA5);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (en_cnt - b >= 7) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk("abort_reach7", {31'd0, got}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_outputs", {27'd0, busy, config_enable, chain_clk_en, data_ready, done}, 32'd0);
    repeat (5) tick();
    chk("abort_no_done", done_cnt - db, 0);
    chk("abort_stay_idle", {30'd0, busy, config_enable}, 32'd0);
    b = en_cnt; hv = hold_viol;
    run_load(8'hA5, 8'h3C, 8'hC0, 0);
    check_load("reload", b, hv, 0);

    // Asynchronous reset in the middle of a load.
    b = en_cnt;
    pulse_start();
    send_word(8'hA5);
    for (int i = 0; i < 50; i++) begin
      if (en_cnt - b >= 3) break;
      tick();
    end
    #2;
    pReset = 1'b1;
    #1;
    chk("async_reset_outputs", {26'd0, data_ready, ccff_head, chain_clk_en, config_enable, busy, done}, 32'd0);
    tick();
    pReset = 1'b0;
    repeat (4) tick();
    chk("reset_idle", {29'd0, busy, config_enable, data_ready}, 32'd0);

    // start held high through a load: only one load, one done.
    b = en_cnt; db = done_cnt; hv = hold_viol;
    tick();
    start = 1'b1;
    send_word(8'hA5);
    send_word(8'h3C);
    send_word(8'hC0);
    start = 1'b0;
    wait_done();
    check_load("start_held", b, hv, 0);
    chk("start_held_one_done", done_cnt - db, 1);

    // start together with abort in IDLE: nothing happens.
    db = done_cnt;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_idle", {29'd0, busy, config_enable, data_ready}, 32'd0);
    repeat (3) tick();
    chk("start_abort_no_done", done_cnt - db, 0);

`ifdef CCFF_TAIL_CRC_EN
    // Two identical all-ones loads into a cleared chain.
    chain_clr = 1'b1;
    tick();
    chain_clr = 1'b0;
    run_load(8'hFF, 8'hFF, 8'hC0, 0);
    chk("crc_first_zeros", {24'd0, tail_crc}, 32'h00);
    run_load(8'hFF, 8'hFF, 8'hC0, 0);
    chk("crc_second_ones", {24'd0, tail_crc}, 32'h99);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Drives the configuration-chain head of a tile column.
- Accepts bitstream words from the configuration host over a valid/ready handshake and serialises them MSB-first onto ccff_head.
- Generates config_enable and a per-bit chain clock enable, and observes ccff_tail at the far end of the chain.
- Sits between the bitstream host interface and the first grid tile's ccff_head.

Parameters:
CHAIN_LEN, 18, total configuration bits in the chain (legal range 1 to 65535)
WORD_W, 8, width of the host bitstream word (legal range 1 to 32)
CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN

Ports:
prog_clk  input  1  programming clock; all state updates on its rising edge
pReset  input  1  asynchronous active-high reset
start  input  1  one-cycle request to begin a load; ignored while busy=1
abort  input  1  synchronous abort; returns to IDLE and discards buffered data
data_in  input  WORD_W  bitstream word; bit WORD_W-1 is shifted first
data_valid  input  1  data_in is valid
data_ready  output  1  loader can accept a word this cycle
ccff_head  output  1  serial configuration bit to the chain
chain_clk_en  output  1  chain shifts on this prog_clk edge (drives the chain clock gate)
config_enable  output  1  configuration mode to the fabric
ccff_tail  input  1  serial bit returning from the chain end
busy  output  1  load in progress
done  output  1  one-cycle pulse after the last bit is shifted

Behaviour:
- Reset values (asynchronous, pReset=1): state=IDLE; data_ready=0, ccff_head=0, chain_clk_en=0, config_enable=0, busy=0, done=0; counters and buffers cleared.
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE -> LOAD on start=1. busy and config_enable go high on the next cycle. bit_cnt is cleared.
- Buffering: one hold register plus one shift register.
  - data_ready=1 in LOAD when the hold register is empty, or will empty this cycle.
  - A word is accepted on data_valid & data_ready.
  - When the shift register is empty, or is emitting its last useful bit, and the hold register is full, the hold word moves into the shift register on the same edge. Streaming therefore has no bubbles.
- Shifting:
  - When the shift register holds a useful bit: ccff_head = shift MSB, chain_clk_en=1, bit_cnt increments, shift register moves left.
  - When starved: chain_clk_en=0 and ccff_head holds its last value. The chain must never shift on a starved cycle.
- Total words = ceil(CHAIN_LEN/WORD_W).
  - On the final word only the top (CHAIN_LEN - (words-1)*WORD_W) bits are shifted; the remaining low bits are discarded.
  - data_ready stays 0 once the final word is accepted.
- LOAD -> DRAIN when the last word is accepted. DRAIN -> DONE when bit_cnt reaches CHAIN_LEN.
- DONE lasts one cycle: done=1, config_enable=0, busy=0. Then IDLE.
- Exactly CHAIN_LEN cycles with chain_clk_en=1 occur per load.
- abort=1 in any non-IDLE state: next cycle IDLE, chain_clk_en=0, config_enable=0, busy=0, done not pulsed, buffers emptied. abort has priority over start and over data acceptance.
- start=1 while busy: ignored. start and abort in the same IDLE cycle: stay IDLE.
- pReset mid-load: immediate return to reset values; partial chain contents are left undefined.
- ccff_tail is sampled only by the optional feature.

Optional Feature:
- Macro: CCFF_TAIL_CRC_EN.
- Defined:
  - Adds output tail_crc [7:0], reset 0x00.
  - CRC-8 (poly 0x07, init 0x00, serial MSB-first) computed over ccff_tail on every chain_clk_en=1 cycle.
  - Update: c' = {c[6:0],0} ^ ((c[7]^ccff_tail) ? 0x07 : 0x00).
  - Cleared when a load starts; final value stable from the done pulse until the next start.
  - Reloading identical data lets the host verify the previous contents.
- Undefined: no tail_crc port and no CRC logic; ccff_tail is left unused.

Test Plan:
- Defaults (CHAIN_LEN=18, WORD_W=8), start, words 0xA5, 0x3C, 0xC0 with data_valid held high -> ccff_head sequence 10100101 00111100 11; 18 consecutive chain_clk_en cycles; done pulses once; low 6 bits of 0xC0 are never shifted.
- Same load with data_valid low for 5 cycles after the first word -> chain_clk_en=0 for exactly the starved cycles; ccff_head holds; total enabled cycles still 18.
- abort asserted after 7 shifted bits -> next cycle busy=0, config_enable=0, no done pulse; a new start then loads a full 18 bits correctly.
- pReset pulse mid-load -> all outputs 0 asynchronously, before the next prog_clk edge; state returns to IDLE.
- start held high during a load, and start together with abort in IDLE -> no second load and no state change; exactly one done pulse per real load.
- With CCFF_TAIL_CRC_EN, a chain model of length 18, two loads of 0xFF, 0xFF, 0xC0 -> the second tail_crc equals CRC-8 of 18 ones; the first equals CRC-8 of 18 zeros (0x00).
